// File: rtl/mul_share_sched.sv
// Round-robin scheduler that shares one repeated-addition multiplier
// datapath (A register, B down-counter, P accumulator) among NREQ requesters.
// It arbitrates in IDLE, steers the winner's operands onto the datapath and
// sequences load/clear/accumulate/decrement, then pulses done to the winner.
module mul_share_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    input  logic                    eqz,
    output logic [WIDTH-1:0]        opnd_a,
    output logic [WIDTH-1:0]        opnd_b,
    output logic                    ld_a,
    output logic                    ld_b,
    output logic                    clr_p,
    output logic                    ld_p,
    output logic                    dec_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy
);

    localparam int unsigned NR   = NREQ;
    localparam int          SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CHECK,
        ACC,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] rr_ptr;
    logic            fresh;
    logic [SELW-1:0] winner;
    logic            any_req;

    // Round-robin winner search. rr_ptr resets to 0, so 'fresh' marks that no
    // winner has been recorded yet and the search must start at requester 0
    // rather than rr_ptr+1.
    always_comb begin
        int unsigned idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (fresh) begin
                idx = k;
            end else begin
                idx = (32'(rr_ptr) + 32'd1 + k) % NR;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = SELW'(idx);
            end
        end
    end

    // State register with winner capture; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
            fresh  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                sel    <= winner;
                rr_ptr <= winner;
                fresh  <= 1'b0;
            end
        end
    end

    // Next-state logic and control decode from state only.
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        clr_p     = 1'b0;
        ld_p      = 1'b0;
        dec_b     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                ld_a      = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                ld_b      = 1'b1;
                clr_p     = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = eqz ? DONE : ACC;
            end
            ACC: begin
                ld_p      = 1'b1;
                dec_b     = 1'b1;
                state_nxt = CHECK;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-hot grant/done pulses steered by the captured winner.
    always_comb begin
        gnt  = '0;
        done = '0;
        if (state == LOAD_B) gnt[sel] = 1'b1;
        if (state == DONE)   done[sel] = 1'b1;
    end

    assign busy   = (state != IDLE);
    assign opnd_a = a_in[int'(sel)*WIDTH +: WIDTH];
    assign opnd_b = b_in[int'(sel)*WIDTH +: WIDTH];

endmodule
